wrr_arbiter: RTL

Parametrised weighted round-robin arbiter with an internal rotating pointer, per-channel programmable weights, and a weight cap. It picks one requester, holds the grant for that channel's weight in cycles, then hands off to the next requester in circular order with no idle cycle. It replaces single-weight, externally-pointed grant logic in front of shared resources such as a bus, memory port or output link.

---
 rtl/wrr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with a rotating search pointer and per-channel burst weights.
// Each grant is held for the channel's effective weight, which is latched when the burst starts.
module wrr_arbiter #(
  parameter int CHANNELS     = 8,
  parameter int WEIGHT_W     = 4,
  parameter int WEIGHT_LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          request,
  input  logic [CHANNELS*WEIGHT_W-1:0] weight,
  input  logic                         weight_load,
  output logic [CHANNELS-1:0]          gnt,
  output logic [$clog2(CHANNELS)-1:0]  gnt_id,
  output logic                         gnt_valid,
  output logic                         burst_done
);
  localparam int IW = $clog2(CHANNELS);
  localparam int CW = $clog2(WEIGHT_LIMIT + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state, w_state_next;
  logic [WEIGHT_W-1:0] r_weight [CHANNELS];
  logic [IW-1:0]       r_pointer, r_cur;
  logic [CW-1:0]       r_cnt, r_eff;
  logic [CHANNELS-1:0] r_gnt;
  logic                r_done;

  logic [IW-1:0]       w_cur_inc, w_start, w_sel, w_idx, w_pointer_next, w_cur_next;
  logic                w_found, w_term, w_done_next;
  logic [CW-1:0]       w_sel_eff, w_cnt_next, w_eff_next;
  logic [CHANNELS-1:0] w_gnt_next;

  assign w_cur_inc = (r_cur == IW'(CHANNELS - 1)) ? '0 : r_cur + IW'(1);
  assign w_term    = (r_state == S_GRANT) && (!request[r_cur] || (r_cnt == r_eff));
  // After a burst the search restarts just past the finished channel, so it is visited last.
  assign w_start   = (r_state == S_GRANT) ? w_cur_inc : r_pointer;

  // Descending scan: the lowest circular offset from w_start is assigned last and wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_idx = IW'((int'(w_start) + k) % CHANNELS);
      if (request[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    if (r_weight[w_sel] == '0)
      w_sel_eff = CW'(1);
    else if (int'(r_weight[w_sel]) > WEIGHT_LIMIT)
      w_sel_eff = CW'(WEIGHT_LIMIT);
    else
      w_sel_eff = CW'(r_weight[w_sel]);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_GRANT;
      S_GRANT: if (w_term && !w_found) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_next     = r_gnt;
    w_cur_next     = r_cur;
    w_cnt_next     = r_cnt;
    w_eff_next     = r_eff;
    w_pointer_next = r_pointer;
    w_done_next    = 1'b0;
    if ((r_state == S_GRANT) && !w_term) begin
      w_cnt_next = r_cnt + CW'(1);
    end else begin
      if (w_term) begin
        w_done_next    = 1'b1;
        w_pointer_next = w_cur_inc;
      end
      if (w_found) begin
        w_gnt_next = {{(CHANNELS-1){1'b0}}, 1'b1} << w_sel;
        w_cur_next = w_sel;
        w_cnt_next = CW'(1);
        w_eff_next = w_sel_eff;
      end else begin
        w_gnt_next = '0;
        w_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_cur     <= '0;
      r_cnt     <= '0;
      r_eff     <= '0;
      r_pointer <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_gnt     <= w_gnt_next;
      r_cur     <= w_cur_next;
      r_cnt     <= w_cnt_next;
      r_eff     <= w_eff_next;
      r_pointer <= w_pointer_next;
      r_done    <= w_done_next;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_weight
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_weight[gi] <= WEIGHT_W'(1);
      else if (weight_load)
        r_weight[gi] <= weight[gi*WEIGHT_W +: WEIGHT_W];
    end
  end

  always_comb begin
    gnt        = r_gnt;
    gnt_id     = r_cur;
    gnt_valid  = (r_state == S_GRANT);
    burst_done = r_done;
  end
endmodule
